// File: rtl/burst_capture_tx_if.sv
// Upstream word stream into burst_capture_tx: one 16-bit word plus an
// end-of-packet flag per transfer.
interface burst_capture_tx_if #(
  parameter int DATA_W = 16
);
  // A word transfers on a rising clock edge where s_valid && s_ready.
  // s_data/s_eop must be stable while s_valid is high.
  // s_ready depends only on buffer occupancy, never on s_valid.
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_eop;

  modport master (output s_valid, s_data, s_eop, input s_ready);
  modport slave  (input s_valid, s_data, s_eop, output s_ready);
endinterface

// File: rtl/burst_capture_tx.sv
// Transmit partner of the clock-gated capture bank: buffers upstream words and
// drives (tx_valid, tx_last, tx_data) as load / fill / hold actions in packets.
module burst_capture_tx #(
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 4,
  parameter int MAX_BEATS = 8,
  localparam int CW       = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1,
  localparam int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                clk,
  input  logic                rst_b,
  burst_capture_tx_if.slave   s_if,
  input  logic                fill_req,
  input  logic                tx_en,
  output logic                tx_valid,
  output logic                tx_last,
  output logic [DATA_W-1:0]   tx_data,
  output logic                busy,
  output logic [CW-1:0]       beat_cnt,
  output logic                underrun,
  output logic                dbg_state
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BEATS - 1);

  logic [DATA_W:0] r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic [0:0]      r_state;
  logic            r_fill_pend;

  logic            w_push;
  logic            w_pop;
  logic            w_empty;
  logic [DATA_W:0] w_head;
  logic [AW:0]     w_count_nxt;
  logic [0:0]      w_state_nxt;
  logic            w_fill_issue;
  logic            w_valid_nxt;
  logic            w_last_nxt;
  logic [DATA_W-1:0] w_data_nxt;
  logic [CW-1:0]   w_cnt_nxt;
  logic            w_under_nxt;

  assign s_if.s_ready = (r_count != FULL_CNT);
  assign w_push       = s_if.s_valid && s_if.s_ready;
  assign w_empty      = (r_count == '0);
  assign w_head       = r_mem[r_rd_ptr];
  assign dbg_state    = r_state;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)      w_count_nxt = r_count + (AW + 1)'(1);
    else if (!w_push && w_pop) w_count_nxt = r_count - (AW + 1)'(1);
  end

  // Action selection; fill beats waiting data and is only legal between packets.
  always_comb begin
    w_state_nxt  = r_state;
    w_pop        = 1'b0;
    w_fill_issue = 1'b0;
    w_valid_nxt  = 1'b0;
    w_last_nxt   = 1'b1;
    w_data_nxt   = tx_data;
    w_cnt_nxt    = beat_cnt;
    w_under_nxt  = 1'b0;
    if (!tx_en) begin
      w_last_nxt = 1'b1;
    end else if (r_state == ST_IDLE && r_fill_pend) begin
      w_fill_issue = 1'b1;
      w_last_nxt   = 1'b0;
    end else if (!w_empty) begin
      w_pop       = 1'b1;
      w_valid_nxt = 1'b1;
      w_data_nxt  = w_head[DATA_W-1:0];
      if (r_state == ST_IDLE) begin
        if (w_head[DATA_W] || MAX_BEATS == 1) begin
          w_last_nxt = 1'b1;
          w_cnt_nxt  = '0;
        end else begin
          w_last_nxt  = 1'b0;
          w_cnt_nxt   = CW'(1);
          w_state_nxt = ST_SEND;
        end
      end else begin
        // A length-forced last leaves any later eop for the next packet.
        if (w_head[DATA_W] || beat_cnt == LAST_BEAT) begin
          w_last_nxt  = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_last_nxt = 1'b0;
          w_cnt_nxt  = beat_cnt + CW'(1);
        end
      end
    end else if (r_state == ST_SEND) begin
      w_under_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {s_if.s_eop, s_if.s_data};
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_state     <= ST_IDLE;
      r_fill_pend <= 1'b0;
      tx_valid    <= 1'b0;
      tx_last     <= 1'b1;
      tx_data     <= '0;
      beat_cnt    <= '0;
      underrun    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count     <= w_count_nxt;
      r_state     <= w_state_nxt;
      r_fill_pend <= w_fill_issue ? 1'b0 : (r_fill_pend | fill_req);
      tx_valid    <= w_valid_nxt;
      tx_last     <= w_last_nxt;
      tx_data     <= w_data_nxt;
      beat_cnt    <= w_cnt_nxt;
      underrun    <= w_under_nxt;
      busy        <= (w_state_nxt == ST_SEND) || (w_count_nxt != '0);
    end
  end

endmodule

// File: tb/tb_burst_capture_tx.sv
// Bench for burst_capture_tx: directed scenarios then random traffic, all
// checked cycle by cycle against a packet-level reference model.
module tb_burst_capture_tx;
  localparam int DATA_W    = 16;
  localparam int DEPTH     = 4;
  localparam int MAX_BEATS = 8;

  logic        clk;
  logic        rst_b;
  logic        fill_req;
  logic        tx_en;
  logic        tx_valid;
  logic        tx_last;
  logic [15:0] tx_data;
  logic        busy;
  logic [2:0]  beat_cnt;
  logic        underrun;
  logic        dbg_state;

  int checks = 0;
  int errors = 0;

  burst_capture_tx_if #(.DATA_W(DATA_W)) s_if ();

  burst_capture_tx #(.DATA_W(DATA_W), .DEPTH(DEPTH), .MAX_BEATS(MAX_BEATS)) dut (
    .clk(clk), .rst_b(rst_b), .s_if(s_if), .fill_req(fill_req), .tx_en(tx_en),
    .tx_valid(tx_valid), .tx_last(tx_last), .tx_data(tx_data), .busy(busy),
    .beat_cnt(beat_cnt), .underrun(underrun), .dbg_state(dbg_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: queue of buffered {eop,data}, packet progress in beats sent.
  logic [16:0] mq[$];
  bit          in_pkt;
  int          beats;
  bit          pend;
  logic        e_valid, e_last, e_under, e_busy;
  logic [15:0] e_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    in_pkt = 0; beats = 0; pend = 0;
    e_valid = 0; e_last = 1; e_data = '0; e_under = 0; e_busy = 0;
  endtask

  task automatic check_outputs();
    chk("tx_valid", tx_valid, e_valid);
    chk("tx_last", tx_last, e_last);
    chk("tx_data", tx_data, e_data);
    chk("beat_cnt", beat_cnt, beats);
    chk("underrun", underrun, e_under);
    chk("busy", busy, e_busy);
    chk("state", dbg_state, in_pkt);
  endtask

  task automatic cycle(input logic v, input logic [15:0] d, input logic e,
                       input logic f, input logic en);
    bit          acc;
    bit          fill_now;
    logic [16:0] w;
    s_if.s_valid = v; s_if.s_data = d; s_if.s_eop = e;
    fill_req = f; tx_en = en;
    chk("s_ready", s_if.s_ready, mq.size() < DEPTH);
    acc = v && (mq.size() < DEPTH);
    fill_now = 0;
    e_under = 0;
    if (!en) begin
      e_valid = 0; e_last = 1;
    end else if (!in_pkt && pend) begin
      e_valid = 0; e_last = 0; fill_now = 1;
    end else if (mq.size() != 0) begin
      w = mq.pop_front();
      beats++;
      e_valid = 1; e_data = w[15:0];
      e_last = w[16] || (beats == MAX_BEATS);
      if (e_last) begin in_pkt = 0; beats = 0; end
      else in_pkt = 1;
    end else begin
      e_valid = 0; e_last = 1; e_under = in_pkt;
    end
    pend = fill_now ? 0 : (pend | f);
    if (acc) mq.push_back({e, d});
    e_busy = in_pkt || (mq.size() != 0);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    rst_b = 1'b1;
    s_if.s_valid = 0; s_if.s_data = '0; s_if.s_eop = 0;
    fill_req = 0; tx_en = 0;
    model_reset();
    #2 rst_b = 1'b0;
    #1;
    check_outputs();
    chk("reset_s_ready", s_if.s_ready, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst_b = 1'b1;

    // Two-word packet back to back
    cycle(1, 16'h1234, 0, 0, 1);
    cycle(1, 16'hABCD, 1, 0, 1);
    idle(3);

    // Ten words without eop: forced last on beat eight
    for (int i = 0; i < 10; i++) cycle(1, 16'h0100 + 16'(i), 0, 0, 1);
    cycle(0, 16'h0, 0, 0, 1);
    cycle(1, 16'h0200, 1, 0, 1);
    idle(3);

    // Fill requested mid-packet is deferred past the packet's last beat
    cycle(1, 16'hA001, 0, 0, 0);
    cycle(1, 16'hA002, 0, 0, 0);
    cycle(1, 16'hA003, 1, 0, 0);
    cycle(1, 16'hA004, 1, 0, 0);
    cycle(0, 16'h0, 0, 0, 1);
    cycle(0, 16'h0, 0, 1, 1);
    idle(5);

    // Full buffer with transmit disabled, then drain
    for (int i = 0; i < 5; i++) cycle(1, 16'hB000 + 16'(i), i == 3, 0, 0);
    cycle(0, 16'h0, 0, 0, 0);
    idle(6);

    // Late second word produces underrun holds
    cycle(1, 16'hC001, 0, 0, 1);
    idle(3);
    cycle(1, 16'hC002, 0, 0, 1);
    cycle(1, 16'hC003, 1, 0, 1);
    idle(3);

    // Reset in the middle of a packet with words buffered
    cycle(1, 16'hD001, 0, 0, 1);
    cycle(1, 16'hD002, 0, 0, 1);
    cycle(1, 16'hD003, 0, 0, 1);
    cycle(1, 16'hD004, 1, 0, 0);
    s_if.s_valid = 0;
    rst_b = 1'b0;
    model_reset();
    #1;
    check_outputs();
    chk("midrst_s_ready", s_if.s_ready, 1'b1);
    @(posedge clk);
    #1 rst_b = 1'b1;
    idle(4);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 3) == 0,
            $urandom_range(0, 15) == 0, $urandom_range(0, 7) != 0);
    end
    idle(12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
